ni_irq_csr_bank: RTL

//  Parametrised NI CSR bank and IRQ controller, one per router NI on the AXI clock.
//  - Holds read-only ID/version/packet-size regs and per-VC IRQ config (mode, threshold, coalescing timeout).
//  - Keeps sticky write-1-to-clear IRQ status with per-VC coalescing counters.
//  - Generalises the fixed single-mux CSR to NUM_VC channels, each with independent mode.

---
 rtl/ni_irq_csr_bank.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ni_irq_csr_bank.sv
// NI CSR bank with per-VC interrupt sources, coalescing counters and sticky W1C status.
// One instance per router NI. Every request gets a registered response one cycle later.
module ni_irq_csr_bank #(
  parameter int unsigned NUM_VC      = 3,
  parameter int unsigned OCUP_W      = 16,
  parameter int unsigned PKT_W       = 8,
  parameter int unsigned COAL_W      = 16,
  parameter logic [15:0] CSR_BASE    = 16'h1000,
  parameter logic [15:0] ROUTER_X_ID = 16'd0,
  parameter logic [15:0] ROUTER_Y_ID = 16'd0,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                       clk_axi,
  input  logic                       arst_axi,
  input  logic                       csr_valid_i,
  input  logic                       csr_wr_i,
  input  logic [15:0]                csr_addr_i,
  input  logic [31:0]                csr_wdata_i,
  output logic                       csr_ready_o,
  output logic                       csr_rvalid_o,
  output logic [31:0]                csr_rdata_o,
  output logic                       csr_error_o,
  input  logic [NUM_VC-1:0]          empty_vc_i,
  input  logic [NUM_VC-1:0]          full_vc_i,
  input  logic [NUM_VC*OCUP_W-1:0]   ocup_vc_i,
  input  logic [NUM_VC*PKT_W-1:0]    pkt_size_vc_i,
  output logic [NUM_VC-1:0]          irq_vc_o,
  output logic                       irq_trig_o
);

  localparam logic [15:0] VC_END = 16'(16 + 16 * NUM_VC);

  // Architectural state
  logic [NUM_VC-1:0] status_q, status_d;
  logic              en_q, en_d;
  logic [1:0]        mode_q    [NUM_VC];
  logic [1:0]        mode_d    [NUM_VC];
  logic [OCUP_W-1:0] thresh_q  [NUM_VC];
  logic [OCUP_W-1:0] thresh_d  [NUM_VC];
  logic [COAL_W-1:0] timeout_q [NUM_VC];
  logic [COAL_W-1:0] timeout_d [NUM_VC];
  logic [COAL_W-1:0] cnt_q     [NUM_VC];
  logic [COAL_W-1:0] cnt_d     [NUM_VC];

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  // Address decode
  logic [15:0] off, vc_off;
  logic [11:0] vc_idx;
  logic [1:0]  vc_reg;
  logic        hit_ver, hit_id, hit_sts, hit_en, hit_vc;
  logic        ro_hit, mapped, acc_err, wr_ok;

  assign off     = csr_addr_i - CSR_BASE;
  assign vc_off  = off - 16'h0010;
  assign vc_idx  = vc_off[15:4];
  assign vc_reg  = vc_off[3:2];
  assign hit_ver = (off == 16'h0000);
  assign hit_id  = (off == 16'h0004);
  assign hit_sts = (off == 16'h0008);
  assign hit_en  = (off == 16'h000C);
  assign hit_vc  = (off >= 16'h0010) && (off < VC_END) && (off[1:0] == 2'b00);
  assign ro_hit  = hit_ver | hit_id | (hit_vc && (vc_reg == 2'd3));
  assign mapped  = hit_ver | hit_id | hit_sts | hit_en | hit_vc;
  assign acc_err = (off[1:0] != 2'b00) || !mapped || (csr_wr_i && ro_hit);
  assign wr_ok   = csr_valid_i && csr_wr_i && !acc_err;

  // Only the low bits of the write data reach any register.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata_i;

  logic [NUM_VC-1:0] cond, fire, wr_mode, wr_thr, wr_to;

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic sel;
      assign sel         = hit_vc && (vc_idx == 12'(gi));
      assign wr_mode[gi] = wr_ok && sel && (vc_reg == 2'd0);
      assign wr_thr[gi]  = wr_ok && sel && (vc_reg == 2'd1);
      assign wr_to[gi]   = wr_ok && sel && (vc_reg == 2'd2);

      assign cond[gi] = (mode_q[gi] == 2'd0) ? ~empty_vc_i[gi] :
                        (mode_q[gi] == 2'd1) ? full_vc_i[gi] :
                        (mode_q[gi] == 2'd2) ? (ocup_vc_i[gi*OCUP_W +: OCUP_W] >= thresh_q[gi]) :
                        1'b0;
      assign fire[gi] = cond[gi] && (cnt_q[gi] >= timeout_q[gi]);

      // Counter saturates at TIMEOUT; reconfiguring the source restarts the window.
      assign cnt_d[gi] = (wr_mode[gi] || wr_to[gi]) ? '0 :
                         !cond[gi]                  ? '0 :
                         (cnt_q[gi] < timeout_q[gi]) ? cnt_q[gi] + COAL_W'(1) :
                         cnt_q[gi];

      assign mode_d[gi]    = wr_mode[gi] ? csr_wdata_i[1:0]        : mode_q[gi];
      assign thresh_d[gi]  = wr_thr[gi]  ? csr_wdata_i[OCUP_W-1:0] : thresh_q[gi];
      assign timeout_d[gi] = wr_to[gi]   ? csr_wdata_i[COAL_W-1:0] : timeout_q[gi];
    end
  endgenerate

  // A new event outranks a simultaneous W1C of the same bit.
  always_comb begin
    status_d = status_q;
    if (wr_ok && hit_sts) begin
      status_d = status_q & ~csr_wdata_i[NUM_VC-1:0];
    end
    status_d = status_d | fire;
    en_d = (wr_ok && hit_en) ? csr_wdata_i[0] : en_q;
  end

  always_comb begin
    rdata_d  = '0;
    rvalid_d = csr_valid_i;
    error_d  = csr_valid_i && acc_err;
    if (hit_ver) rdata_d = VERSION;
    if (hit_id)  rdata_d = {ROUTER_Y_ID, ROUTER_X_ID};
    if (hit_sts) rdata_d = 32'(status_q);
    if (hit_en)  rdata_d = 32'(en_q);
    for (int i = 0; i < NUM_VC; i++) begin
      if (hit_vc && (vc_idx == 12'(i))) begin
        case (vc_reg)
          2'd0:    rdata_d = 32'(mode_q[i]);
          2'd1:    rdata_d = 32'(thresh_q[i]);
          2'd2:    rdata_d = 32'(timeout_q[i]);
          default: rdata_d = 32'(pkt_size_vc_i[i*PKT_W +: PKT_W]);
        endcase
      end
    end
    if (!csr_valid_i || csr_wr_i || acc_err) rdata_d = '0;
  end

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      status_q <= '0;
      en_q     <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
        mode_q[i]    <= '0;
        thresh_q[i]  <= '1;
        timeout_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
    end else begin
      status_q <= status_d;
      en_q     <= en_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      for (int i = 0; i < NUM_VC; i++) begin
        mode_q[i]    <= mode_d[i];
        thresh_q[i]  <= thresh_d[i];
        timeout_q[i] <= timeout_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
    end
  end

  assign csr_ready_o  = 1'b1;
  assign csr_rvalid_o = rvalid_q;
  assign csr_rdata_o  = rdata_q;
  assign csr_error_o  = error_q;
  assign irq_vc_o     = status_q & {NUM_VC{en_q}};
  assign irq_trig_o   = |irq_vc_o;

endmodule
